// File: rtl/chipper_pkg.sv
// Shared constants for the CHIPPER deflection-router output-port allocator.
// Port codes: N=0, S=1, E=2, W=3, L=4, NONE=3'b111 (idle crossbar select).
package chipper_pkg;

    localparam int unsigned DIR_W = 3;
    localparam int unsigned NPORT = 5;
    localparam int unsigned NNET  = 4;
    localparam int unsigned SEL_W = DIR_W * NPORT;

    localparam logic [DIR_W-1:0] PORT_N    = 3'd0;
    localparam logic [DIR_W-1:0] PORT_S    = 3'd1;
    localparam logic [DIR_W-1:0] PORT_E    = 3'd2;
    localparam logic [DIR_W-1:0] PORT_W    = 3'd3;
    localparam logic [DIR_W-1:0] PORT_L    = 3'd4;
    localparam logic [DIR_W-1:0] PORT_NONE = 3'b111;

    // Lowest-index free network output, or PORT_NONE when all four are taken.
    function automatic logic [DIR_W-1:0] lowest_free_net(input logic [NNET-1:0] free);
        logic [DIR_W-1:0] r;
        r = PORT_NONE;
        for (int i = int'(NNET) - 1; i >= 0; i--) begin
            if (free[i]) r = DIR_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/chipper_prio_order.sv
// Combinational priority ordering of the five router inputs.
// Network inputs 0-3 are listed round-robin starting at ptr; the local
// input 4 always comes last.  With CHIPPER_GOLD_EN defined, valid golden
// network inputs are moved to the front, keeping round-robin order among
// themselves.
// Ports:
//   ptr      - round-robin start pointer (2 bits)
//   vld      - network input valid bits
//   gold     - network input golden flags
//   order_c  - five 3-bit input indices, slot s at bits [3s+2:3s]
module chipper_prio_order
    import chipper_pkg::*;
(
    input  logic [1:0]       ptr,
    input  logic [NNET-1:0]  vld,
    input  logic [NNET-1:0]  gold,
    output logic [SEL_W-1:0] order_c
);

`ifdef CHIPPER_GOLD_EN
    localparam bit GOLD_EN = 1'b1;
`else
    localparam bit GOLD_EN = 1'b0;
`endif

    logic [NNET-1:0]  gold_eff;
    logic [DIR_W-1:0] ord [NPORT];
    logic [DIR_W-1:0] slot;
    logic [1:0]       idx;

    // An invalid input carries no meaningful golden flag.
    assign gold_eff = GOLD_EN ? (gold & vld) : '0;

    // Two passes: golden inputs first, then the rest, both in round-robin order.
    always_comb begin
        for (int s = 0; s < int'(NPORT); s++) ord[s] = PORT_NONE;
        slot    = '0;
        idx     = '0;
        order_c = '1;
        for (int k = 0; k < int'(NNET); k++) begin
            idx = ptr + 2'(k);
            if (gold_eff[idx]) begin
                ord[slot] = {1'b0, idx};
                slot      = slot + 3'd1;
            end
        end
        for (int k = 0; k < int'(NNET); k++) begin
            idx = ptr + 2'(k);
            if (!gold_eff[idx]) begin
                ord[slot] = {1'b0, idx};
                slot      = slot + 3'd1;
            end
        end
        ord[PORT_L] = PORT_L;
        for (int s = 0; s < int'(NPORT); s++) order_c[DIR_W*s +: DIR_W] = ord[s];
    end

endmodule

// File: rtl/chipper_port_alloc.sv
// Per-cycle output-port allocator for the five-port bufferless deflection
// router.  Walks the inputs in priority order; each valid flit takes its
// desired output when free and legal, otherwise the lowest free network
// output (deflection).  Local injection is accepted only if a network output
// is left after the network flits.  Results are registered (1-cycle latency).
// Optional feature: CHIPPER_GOLD_EN (golden-first ordering, in chipper_prio_order).
// Ports:
//   clksig, rstsig_n - clock (rising edge), async active-low reset
//   alloc_en         - allocate and advance this cycle
//   in_vld/in_dir/in_gold - per-input valid, desired port (3b each), golden flag
//   out_sel          - per-output source index (3b each), 3'b111 = idle
//   out_vld          - per-output driven flag
//   defl             - per-input deflection flag
//   inj_ack          - local injection accepted
//   inj_starve       - starvation counter reached STARVE_MAX
module chipper_port_alloc
    import chipper_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic             clksig,
    input  logic             rstsig_n,
    input  logic             alloc_en,
    input  logic [4:0]       in_vld,
    input  logic [14:0]      in_dir,
    input  logic [4:0]       in_gold,
    output logic [14:0]      out_sel,
    output logic [4:0]       out_vld,
    output logic [4:0]       defl,
    output logic             inj_ack,
    output logic             inj_starve
);

    localparam int unsigned          STARVE_W   = 4;
    localparam logic [STARVE_W-1:0]  STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [1:0]          ptr;
    logic [STARVE_W-1:0] starve;
    logic [STARVE_W-1:0] starve_nxt;
    logic [SEL_W-1:0]    order;
    logic [DIR_W-1:0]    dir_a [NPORT];
    logic [DIR_W-1:0]    sel_a [NPORT];
    logic [SEL_W-1:0]    sel_nxt;
    logic [NPORT-1:0]    vld_nxt;
    logic [NPORT-1:0]    defl_nxt;
    logic [NPORT-1:0]    free;
    logic                ack_nxt;
    logic [DIR_W-1:0]    src;
    logic [DIR_W-1:0]    want;
    logic [DIR_W-1:0]    net;
    logic                legal;
    logic                unused_gold_l;

    // The local input is always last, so its golden flag never matters.
    assign unused_gold_l = in_gold[PORT_L];

    chipper_prio_order u_prio (
        .ptr     (ptr),
        .vld     (in_vld[NNET-1:0]),
        .gold    (in_gold[NNET-1:0]),
        .order_c (order)
    );

    // Sequential port assignment in priority order.
    always_comb begin
        free     = '1;
        ack_nxt  = 1'b0;
        defl_nxt = '0;
        sel_nxt  = '1;
        vld_nxt  = '0;
        src      = '0;
        want     = '0;
        net      = PORT_NONE;
        legal    = 1'b0;
        for (int o = 0; o < int'(NPORT); o++) sel_a[o] = PORT_NONE;
        for (int i = 0; i < int'(NPORT); i++) dir_a[i] = in_dir[DIR_W*i +: DIR_W];

        for (int s = 0; s < int'(NPORT); s++) begin
            src  = order[DIR_W*s +: DIR_W];
            want = dir_a[src];
            net  = lowest_free_net(free[NNET-1:0]);
            // Codes 5-7 and local-to-local are "no preference".
            legal = (want <= PORT_L) && !((src == PORT_L) && (want == PORT_L));
            if (in_vld[src]) begin
                if (legal && free[want]) begin
                    sel_a[want] = src;
                    free[want]  = 1'b0;
                    if (src == PORT_L) ack_nxt = 1'b1;
                end else if (net != PORT_NONE) begin
                    sel_a[net]    = src;
                    free[net]     = 1'b0;
                    defl_nxt[src] = 1'b1;
                    if (src == PORT_L) ack_nxt = 1'b1;
                end
            end
        end

        for (int o = 0; o < int'(NPORT); o++) begin
            sel_nxt[DIR_W*o +: DIR_W] = sel_a[o];
            vld_nxt[o]                = (sel_a[o] != PORT_NONE);
        end
    end

    // Saturating count of consecutive refused injections.
    always_comb begin
        starve_nxt = '0;
        if (in_vld[PORT_L] && !ack_nxt) begin
            starve_nxt = (starve == STARVE_LIM) ? starve : starve + 4'd1;
        end
    end

    always_ff @(posedge clksig or negedge rstsig_n) begin
        if (!rstsig_n) begin
            out_sel    <= '1;
            out_vld    <= '0;
            defl       <= '0;
            inj_ack    <= 1'b0;
            inj_starve <= 1'b0;
            ptr        <= '0;
            starve     <= '0;
        end else if (alloc_en) begin
            out_sel    <= sel_nxt;
            out_vld    <= vld_nxt;
            defl       <= defl_nxt;
            inj_ack    <= ack_nxt;
            inj_starve <= (starve_nxt == STARVE_LIM);
            ptr        <= ptr + 2'd1;
            starve     <= starve_nxt;
        end
    end

endmodule

// File: tb/tb_chipper_port_alloc.sv
// Self-checking bench for chipper_port_alloc: directed steps from the
// allocator rules followed by randomized traffic checked against a
// queue-based reference model.
module tb_chipper_port_alloc;

    logic        clksig;
    logic        rstsig_n;
    logic        alloc_en;
    logic [4:0]  in_vld;
    logic [14:0] in_dir;
    logic [4:0]  in_gold;
    logic [14:0] out_sel;
    logic [4:0]  out_vld;
    logic [4:0]  defl;
    logic        inj_ack;
    logic        inj_starve;

    int checks   = 0;
    int failures = 0;

    int          m_ptr;
    int          m_starve;
    logic [14:0] e_sel;
    logic [4:0]  e_vld;
    logic [4:0]  e_defl;
    logic        e_ack;
    logic        e_starve;

    chipper_port_alloc #(.STARVE_MAX(15)) dut (
        .clksig     (clksig),
        .rstsig_n   (rstsig_n),
        .alloc_en   (alloc_en),
        .in_vld     (in_vld),
        .in_dir     (in_dir),
        .in_gold    (in_gold),
        .out_sel    (out_sel),
        .out_vld    (out_vld),
        .defl       (defl),
        .inj_ack    (inj_ack),
        .inj_starve (inj_starve)
    );

    initial clksig = 1'b0;
    always #5 clksig = ~clksig;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dir(input int i, input int d);
        in_dir[3*i +: 3] = 3'(d);
    endtask

    task automatic model_reset();
        e_sel    = '1;
        e_vld    = '0;
        e_defl   = '0;
        e_ack    = 1'b0;
        e_starve = 1'b0;
        m_ptr    = 0;
        m_starve = 0;
    endtask

    // Reference allocation from the rules: build the priority list, then place flits.
    task automatic model_alloc();
        int prio[$];
        bit taken[5];
        int sel[5];
        bit gold_en;
        int n;
        int i;
        int d;
        int g;
`ifdef CHIPPER_GOLD_EN
        gold_en = 1'b1;
`else
        gold_en = 1'b0;
`endif
        prio = {};
        for (int k = 0; k < 4; k++) begin
            n = (m_ptr + k) % 4;
            if (gold_en && in_vld[n] && in_gold[n]) prio.push_back(n);
        end
        for (int k = 0; k < 4; k++) begin
            n = (m_ptr + k) % 4;
            if (!(gold_en && in_vld[n] && in_gold[n])) prio.push_back(n);
        end
        prio.push_back(4);
        for (int o = 0; o < 5; o++) begin
            taken[o] = 1'b0;
            sel[o]   = 7;
        end
        e_defl = '0;
        e_ack  = 1'b0;
        foreach (prio[p]) begin
            i = prio[p];
            d = int'(in_dir[3*i +: 3]);
            g = -1;
            if (in_vld[i]) begin
                if ((d < 4 || (d == 4 && i != 4)) && !taken[d]) begin
                    g = d;
                end else begin
                    for (int o = 3; o >= 0; o--) if (!taken[o]) g = o;
                    if (g >= 0) e_defl[i] = 1'b1;
                end
                if (g >= 0) begin
                    taken[g] = 1'b1;
                    sel[g]   = i;
                    if (i == 4) e_ack = 1'b1;
                end
            end
        end
        for (int o = 0; o < 5; o++) begin
            e_sel[3*o +: 3] = 3'(sel[o]);
            e_vld[o]        = (sel[o] != 7);
        end
        if (in_vld[4] && !e_ack) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        else                     m_starve = 0;
        e_starve = (m_starve == 15);
        m_ptr    = (m_ptr + 1) % 4;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_out_sel"},    out_sel,    e_sel);
        chk({tag, "_out_vld"},    out_vld,    e_vld);
        chk({tag, "_defl"},       defl,       e_defl);
        chk({tag, "_inj_ack"},    inj_ack,    e_ack);
        chk({tag, "_inj_starve"}, inj_starve, e_starve);
    endtask

    task automatic check_invariants();
        int cnt;
        bit ok;
        ok = 1'b1;
        for (int s = 0; s < 5; s++) begin
            cnt = 0;
            for (int o = 0; o < 5; o++) if (int'(out_sel[3*o +: 3]) == s) cnt++;
            if (cnt > 1) ok = 1'b0;
        end
        for (int o = 0; o < 5; o++) if (out_vld[o] != (out_sel[3*o +: 3] != 3'b111)) ok = 1'b0;
        chk("invariants", 32'(ok), 32'd1);
    endtask

    // Inputs are set at a negedge; outputs are checked at the following negedge.
    task automatic step(input bit en, input string tag);
        alloc_en = en;
        if (en) model_alloc();
        @(posedge clksig);
        @(negedge clksig);
        check_all(tag);
    endtask

    task automatic idle_to_ptr0();
        in_vld = '0;
        while (m_ptr != 0) step(1'b1, "idle");
    endtask

    initial begin
        rstsig_n = 1'b0;
        alloc_en = 1'b0;
        in_vld   = '0;
        in_dir   = '0;
        in_gold  = '0;
        model_reset();
        repeat (2) @(negedge clksig);
        check_all("reset");
        chk("reset_out_sel_lit", out_sel, 15'h7FFF);
        rstsig_n = 1'b1;

        // No conflict, ptr = 0.
        in_vld = 5'b01111;
        set_dir(0, 2); set_dir(1, 3); set_dir(2, 0); set_dir(3, 1);
        step(1'b1, "noconf");
        chk("noconf_sel_lit", out_sel, 15'h721A);
        chk("noconf_vld_lit", out_vld, 5'b01111);

        // Contention at ptr = 1: S wins E, N deflected to output N.
        in_vld = 5'b00011;
        set_dir(0, 2); set_dir(1, 2);
        step(1'b1, "cont_p1");
        chk("cont_p1_sel_lit", out_sel, 15'h7E78);
        chk("cont_p1_defl_lit", defl, 5'b00001);

        // Contention at ptr = 0: N wins E, S deflected to output N.
        idle_to_ptr0();
        in_vld = 5'b00011;
        step(1'b1, "cont_p0");
        chk("cont_p0_sel_lit", out_sel, 15'h7E39);
        chk("cont_p0_defl_lit", defl, 5'b00010);

        // Hold: alloc_en low keeps every output.
        in_vld = 5'b11111;
        step(1'b0, "hold");

        // Injection accepted.
        in_vld = 5'b10001;
        set_dir(0, 2); set_dir(4, 3);
        step(1'b1, "inj_ok");
        chk("inj_ok_ack_lit", inj_ack, 1'b1);
        chk("inj_ok_selW_lit", out_sel[11:9], 3'd4);

        // Injection starvation with all five valid.
        in_vld = 5'b11111;
        set_dir(0, 1); set_dir(1, 0); set_dir(2, 3); set_dir(3, 2); set_dir(4, 0);
        for (int n = 1; n <= 16; n++) begin
            step(1'b1, "starve");
            chk("starve_ack_lit", inj_ack, 1'b0);
            chk("starve_flag_lit", inj_starve, (n >= 15));
        end
        in_vld = 5'b01111;
        step(1'b1, "starve_clr");
        chk("starve_clr_lit", inj_starve, 1'b0);

        // Ejection contention at ptr = 0 and a "no preference" code.
        idle_to_ptr0();
        in_vld = 5'b00101;
        set_dir(0, 4); set_dir(2, 4);
        step(1'b1, "eject");
        chk("eject_selL_lit", out_sel[14:12], 3'd0);
        chk("eject_selN_lit", out_sel[2:0], 3'd2);
        chk("eject_defl_lit", defl, 5'b00100);
        in_vld = 5'b01000;
        set_dir(3, 6);
        step(1'b1, "nopref");
        chk("nopref_selN_lit", out_sel[2:0], 3'd3);
        chk("nopref_defl_lit", defl, 5'b01000);

        // Golden flit ordering.
        idle_to_ptr0();
        in_vld  = 5'b00011;
        in_gold = 5'b00010;
        set_dir(0, 2); set_dir(1, 2);
        step(1'b1, "gold");
`ifdef CHIPPER_GOLD_EN
        chk("gold_selE_lit", out_sel[8:6], 3'd1);
`else
        chk("gold_selE_lit", out_sel[8:6], 3'd0);
`endif

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            in_vld  = 5'($urandom);
            in_gold = 5'($urandom);
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 9) < 8) set_dir(i, int'($urandom_range(0, 4)));
                else                          set_dir(i, int'($urandom_range(5, 7)));
            end
            step(($urandom_range(0, 3) != 0), "rand");
            check_invariants();
        end

        // Reset in the middle of an allocation discards the pending result.
        in_vld   = 5'b11111;
        alloc_en = 1'b1;
        #2 rstsig_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(posedge clksig);
        @(negedge clksig);
        check_all("midrst_edge");
        rstsig_n = 1'b1;
        in_vld   = 5'b00011;
        in_gold  = '0;
        set_dir(0, 2); set_dir(1, 2);
        step(1'b1, "post_rst");
        chk("post_rst_selE_lit", out_sel[8:6], 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chipper_port_alloc.md
# chipper_port_alloc

Per-cycle output-port allocator for the five-port bufferless deflection router (N, S, E, W, L). It takes each input flit's valid bit and desired direction and produces a full input-to-output permutation with a registered crossbar select per output. Every valid network flit always leaves: it gets its desired port or is deflected. Local injection is granted only when a network output is still free. It sits between the route-compute stage and the crossbar of the router pipeline.

## Interface
- `STARVE_MAX`, default 15, consecutive refused injections before `inj_starve` asserts (4-bit counter).
- `clksig` input 1: router clock, rising edge.
- `rstsig_n` input 1: asynchronous active-low reset.
- `alloc_en` input 1: allocate and advance this cycle.
- `in_vld` input 5: flit present per input; index 0=N, 1=S, 2=E, 3=W, 4=L.
- `in_dir` input 15: 3-bit desired output per input, input i at bits [3i+2:3i]; codes 0–4 = N,S,E,W,L.
- `in_gold` input 5: golden-flit flag per input.
- `out_sel` output 15: 3-bit source input index per output, output o at bits [3o+2:3o]; 3'b111 = idle.
- `out_vld` output 5: output driven this cycle.
- `defl` output 5: per input, flit granted a port other than the one requested.
- `inj_ack` output 1: local injection accepted.
- `inj_starve` output 1: injection starvation flag.

## Operation
- **Priority order.** Network inputs 0–3 are ordered round-robin starting at `ptr` (2 bits). With `CHIPPER_GOLD_EN`, golden inputs come first, keeping round-robin order among themselves. Local input 4 is always last.
- **Assignment.** Walk the priority order. Each valid input takes its desired output if that output is free and legal; otherwise it takes the lowest-index free network output (0–3) and sets `defl[i]`.
- **Legality.**
  - Output L accepts only flits with `in_dir` = L, at most one per cycle.
  - Local input 4 may not target L. An L target, or any code 5–7 on any input, is treated as "no preference": take the lowest free network output, `defl` = 1.
- **Injection.**
  - If input 4 is valid and a network output remains free after inputs 0–3 are placed, set `inj_ack` = 1.
  - Otherwise `inj_ack` = 0, input 4 gets no output, `defl[4]` = 0, and the upstream source holds the flit.
- **Network inputs are never dropped.** Four network inputs against four network outputs always fit, so no valid network input is ever refused.
- **Pointer.** `ptr` <= `ptr` + 1 (mod 4) on each edge with `alloc_en` = 1.
- **Starvation counter.** Saturating counter `starve`:
  - increments on each `alloc_en` edge where `in_vld[4]` = 1 and injection is refused;
  - clears on `inj_ack` = 1 or when `in_vld[4]` = 0;
  - holds otherwise.
  - `inj_starve` = (`starve` == `STARVE_MAX`), registered.
- **Hold.** With `alloc_en` = 0, all outputs, `ptr` and `starve` hold.

## Timing
- Inputs are sampled on the `clksig` edge with `alloc_en` = 1; results appear on registered outputs after that edge (1-cycle latency).
- Reset, asynchronous on `rstsig_n` low:
  - `out_sel` = all 3'b111, `out_vld` = 0, `defl` = 0;
  - `inj_ack` = 0, `inj_starve` = 0;
  - `ptr` = 0, `starve` = 0.
- Reset mid-allocation discards the pending result.
- The first allocation after reset uses `ptr` = 0.
- `in_vld` = 0 on an input: that input's `in_dir` and `in_gold` are ignored and it produces no grant.
- Output invariants, every cycle:
  - each input index appears in at most one `out_sel` field;
  - `out_vld[o]` = 1 exactly when `out_sel[o]` != 3'b111.

## Configuration
- `CHIPPER_GOLD_EN` defined: golden-first ordering as described above.
- `CHIPPER_GOLD_EN` undefined: `in_gold` is ignored and ordering is pure round-robin. The port remains present.

## Structure
- Package `chipper_pkg` holds:
  - port constants PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_L=4, PORT_NONE=3'b111;
  - DIR_W=3 and NPORT=5.
- Sub-module `chipper_prio_order`: combinational; takes `ptr`, `in_vld` and `in_gold` and produces the ordered list of five 3-bit input indices. The top level holds the sequential assignment loop, the registers, `ptr` and `starve`.

## Test plan
1. **Reset.** Assert `rstsig_n` low mid-run -> `out_sel` = 15'h7FFF, `out_vld` = 0, `inj_ack` = 0, `inj_starve` = 0. After release, first grant uses `ptr` = 0.
2. **No conflict.** N→E, S→W, E→N, W→S, `alloc_en` = 1 -> `out_sel` N=2, S=3, E=0, W=1, L=7; `out_vld` = 5'b01111; `defl` = 0.
3. **Contention.** N and S both request E at `ptr` = 0 -> N gets E; S deflected to output N with `defl[1]` = 1. Repeat at `ptr` = 1 -> S gets E; N deflected to output N.
4. **Injection.** Only N valid (→E) and L valid (→W) -> `inj_ack` = 1, `out_sel`[W] = 4. All five valid -> `inj_ack` = 0 each cycle; `inj_starve` = 1 after the 15th refusal; one cycle with `in_vld[4]` = 0 clears it.
5. **Ejection.** N→L and E→L at `ptr` = 0 -> N ejects (`out_sel`[L] = 0); E deflected to output N. An input with `in_dir` = 6 -> lowest free network output, `defl` = 1.
6. **Golden.** S golden, N not, both →E, `ptr` = 0. With `CHIPPER_GOLD_EN` -> S gets E. Without it -> N gets E.
